fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO. Next generation of the team's 8x8 queue: configurable width and depth, concurrent read and write in one cycle, and status flags (full, empty, almost-full, almost-empty, occupancy count).
- Separate overflow and underflow indications, with a combined error.
- Sits between producer/consumer blocks in the lab datapaths as the standard buffering element.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wen  input  1  write request
ren  input  1  read request
din  input  WIDTH  write data, sampled on clk rising edge when wen=1
dout  output  WIDTH  read data, registered
valid  output  1  dout updated by a successful read in the previous cycle (1-cycle pulse)
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
almost_full  output  1  count>=AF_LEVEL
almost_empty  output  1  count<=AE_LEVEL
overflow  output  1  previous-cycle write rejected (1-cycle pulse)
underflow  output  1  previous-cycle read rejected (1-cycle pulse)
error  output  1  overflow | underflow

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset: rst=1 immediately forces the following, regardless of clk:
  - head=0, rear=0, count=0.
  - dout=0, valid=0, overflow=0, underflow=0.
  - Flags: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Reset mid-operation discards all stored data. Storage array is not reset.
- Pointers: head (read) and rear (write) are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Read accepted iff ren=1 and count>0:
  - dout<=mem[head], head<=head+1, valid<=1.
  - Latency: data appears on dout the cycle after the accepting edge.
- Write accepted iff wen=1, and either count<DEPTH or a read is accepted in the same cycle:
  - mem[rear]<=din, rear<=rear+1.
- Simultaneous ren=1, wen=1:
  - 0<count<DEPTH: both accepted, count unchanged.
  - count==DEPTH (full): both accepted, count stays DEPTH. Read returns the oldest entry; the write lands in the slot just freed.
  - count==0 (empty): write accepted, read rejected, underflow pulses, count becomes 1. No bypass of din to dout.
- count update: +1 for write-only accepted, -1 for read-only accepted, otherwise unchanged.
- Rejected read: head, count, dout unchanged; valid=0; underflow=1 for exactly the next cycle.
- Rejected write: mem, rear, count unchanged; overflow=1 for the next cycle.
- Idle cycle (ren=0, wen=0): valid, overflow, underflow all return to 0; dout holds its last value.
- dout holds its value on every cycle without an accepted read.
- Flags are combinational decodes of the registered count; they are valid in the same cycle count changes.
- Successive rejected requests keep the pulse asserted on each following cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 entries stored -> outputs immediately reset (count=0, empty=1, dout=0, error=0); a subsequent read -> underflow=1, dout=0.
- Fill/drain, WIDTH=8, DEPTH=8: write 0x11..0x88 -> full=1, count=8, almost_full from count=6. Ninth write 0x99 -> overflow=1 one cycle, count=8. Read 8 -> dout 0x11..0x88 in order, each one cycle after its ren edge; empty=1 at end.
- Wrap-around: write 5, read 5, write 6 (0xA0..0xA5), read 6 -> dout 0xA0..0xA5 in order; rear and head wrapped past 7.
- Simultaneous when full: 8 entries 0x01..0x08, ren=wen=1 with din=0xFF -> dout=0x01, count=8, no error. Then drain -> last read returns 0xFF.
- Simultaneous when empty: ren=wen=1 with din=0x5A -> underflow=1, valid=0, count=1. Next read -> dout=0x5A, valid=1.
- Parameter sweep WIDTH=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: write 0xBEEF, 0xCAFE, 0x1234 -> almost_full=1 at count=3, almost_empty=0 at count=2; reads return the values in order.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised synchronous FIFO. It is the standard buffer placed between
//   producer and consumer blocks. It accepts a read and a write in the same
//   cycle and returns read data one cycle after the accepting edge. It also
//   provides occupancy flags and one-cycle pulses for rejected requests.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   wen / din    write request and write data
//   ren          read request
//   dout         registered read data; holds its value between reads
//   valid        pulse: dout was loaded by a read accepted on the last edge
//   count        occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty
//                decodes of count, same-cycle with count
//   overflow     pulse: the write on the last edge was rejected
//   underflow    pulse: the read on the last edge was rejected
//   error        overflow | underflow
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic                   ren,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage is never reset. Reset clears count, so stale words cannot be read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] rear_q, rear_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_ok, wr_ok;

  always_comb begin
    rd_ok   = ren && (count_q != '0);
    // When the FIFO is full, a write is still accepted if a read frees a
    // slot on the same edge. When it is empty, the read is rejected and din
    // is not forwarded to dout.
    wr_ok   = wen && ((count_q != DEPTH_C) || rd_ok);

    head_d  = head_q;
    rear_d  = rear_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = rd_ok;
    ovf_d   = wen && !wr_ok;
    udf_d   = ren && !rd_ok;

    if (rd_ok) begin
      dout_d = mem_q[head_q];
      head_d = head_q + PTR_W'(1);  // DEPTH is a power of two, so this wraps naturally
    end
    if (wr_ok) rear_d = rear_q + PTR_W'(1);

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      rear_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[rear_q] <= din;
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign error        = ovf_q | udf_q;

endmodule
